// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - shared writeback port arbiter
// Each unit owns a 2-slot buffer; the oldest sqN across all slots wins the port each cycle.
module wb_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int SQN_W   = 6,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 32,
   localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             IN_valid,
   input  logic [NUM_REQ-1:0][SQN_W-1:0]  IN_sqN,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]  IN_tagDst,
   input  logic [NUM_REQ-1:0][4:0]        IN_nmDst,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] IN_result,
   output logic [NUM_REQ-1:0]             OUT_stall,
   input  logic                           IN_invalidate,
   input  logic [SQN_W-1:0]               IN_invalidateSqN,
   output logic                           OUT_valid,
   output logic [SQN_W-1:0]               OUT_sqN,
   output logic [TAG_W-1:0]               OUT_tagDst,
   output logic [4:0]                     OUT_nmDst,
   output logic [DATA_W-1:0]              OUT_result,
   output logic [SRC_W-1:0]               OUT_src,
   output logic [15:0]                    OUT_conflictCnt
);

   // Age comparisons use the wrapped difference; only the sign of a-b is meaningful.
   function automatic logic isOlder(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
      logic [SQN_W-1:0] d;
      d = a - b;
      return d[SQN_W-1];
   endfunction

   function automatic logic isYounger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
      logic [SQN_W-1:0] d;
      d = a - b;
      return !d[SQN_W-1] && (d != '0);
   endfunction

   logic [NUM_REQ-1:0][1:0] slotValid;
   logic [SQN_W-1:0]        slotSqN    [NUM_REQ][2];
   logic [TAG_W-1:0]        slotTag    [NUM_REQ][2];
   logic [4:0]              slotNm     [NUM_REQ][2];
   logic [DATA_W-1:0]       slotResult [NUM_REQ][2];

   logic [NUM_REQ-1:0][1:0] slotKill;
   logic                    grantFound;
   logic [SRC_W-1:0]        grantUnit;
   logic                    grantSlot;
   logic [SQN_W-1:0]        grantSqN;
   logic [NUM_REQ-1:0]      accept;
   logic [NUM_REQ-1:0]      wrSlot;
   logic                    contended;

   // Flushed slots are excluded before the age search so they can never win the port.
   always_comb begin
      slotKill   = '0;
      grantFound = 1'b0;
      grantUnit  = '0;
      grantSlot  = 1'b0;
      grantSqN   = '0;
      for (int u = 0; u < NUM_REQ; u++) begin
         for (int s = 0; s < 2; s++) begin
            logic kill;
            kill = IN_invalidate && slotValid[u][s] && isYounger(slotSqN[u][s], IN_invalidateSqN);
            slotKill[u][s] = kill;
            if (slotValid[u][s] && !kill && (!grantFound || isOlder(slotSqN[u][s], grantSqN))) begin
               grantFound = 1'b1;
               grantUnit  = SRC_W'(u);
               grantSlot  = (s == 1);
               grantSqN   = slotSqN[u][s];
            end
         end
      end
   end

   // Stall and free-slot choice look only at the pre-edge slot state, so a same-cycle pop never frees room.
   always_comb begin
      OUT_stall = '0;
      accept    = '0;
      wrSlot    = '0;
      for (int u = 0; u < NUM_REQ; u++) begin
         OUT_stall[u] = &slotValid[u];
         accept[u]    = IN_valid[u] && !(&slotValid[u]) &&
                        !(IN_invalidate && isYounger(IN_sqN[u], IN_invalidateSqN));
         wrSlot[u]    = slotValid[u][0];
      end
   end

   assign contended = ($countones(slotValid) > 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slotValid <= '0;
         for (int u = 0; u < NUM_REQ; u++) begin
            for (int s = 0; s < 2; s++) begin
               slotSqN[u][s]    <= '0;
               slotTag[u][s]    <= '0;
               slotNm[u][s]     <= '0;
               slotResult[u][s] <= '0;
            end
         end
      end else begin
         for (int u = 0; u < NUM_REQ; u++) begin
            for (int s = 0; s < 2; s++) begin
               if (slotKill[u][s] || (grantFound && (int'(grantUnit) == u) && (int'(grantSlot) == s)))
                  slotValid[u][s] <= 1'b0;
               if (accept[u] && (int'(wrSlot[u]) == s)) begin
                  slotValid[u][s]  <= 1'b1;
                  slotSqN[u][s]    <= IN_sqN[u];
                  slotTag[u][s]    <= IN_tagDst[u];
                  slotNm[u][s]     <= IN_nmDst[u];
                  slotResult[u][s] <= IN_result[u];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         OUT_valid       <= 1'b0;
         OUT_sqN         <= '0;
         OUT_tagDst      <= '0;
         OUT_nmDst       <= '0;
         OUT_result      <= '0;
         OUT_src         <= '0;
         OUT_conflictCnt <= '0;
      end else begin
         OUT_valid <= grantFound;
         if (grantFound) begin
            OUT_sqN    <= grantSqN;
            OUT_tagDst <= slotTag[grantUnit][grantSlot];
            OUT_nmDst  <= slotNm[grantUnit][grantSlot];
            OUT_result <= slotResult[grantUnit][grantSlot];
            OUT_src    <= grantUnit;
         end
         if (contended && (OUT_conflictCnt != 16'hFFFF))
            OUT_conflictCnt <= OUT_conflictCnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized checks of wb_arbiter
// Random traffic is scored against an age-ordered reference model of the slot buffers.
module tb_wb_arbiter;
   localparam int NR = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NR-1:0]        inValid;
   logic [NR-1:0][5:0]   inSq;
   logic [NR-1:0][5:0]   inTag;
   logic [NR-1:0][4:0]   inNm;
   logic [NR-1:0][31:0]  inRes;
   logic [NR-1:0]        outStall;
   logic                 inInv;
   logic [5:0]           inInvSq;
   logic                 outValid;
   logic [5:0]           outSq;
   logic [5:0]           outTag;
   logic [4:0]           outNm;
   logic [31:0]          outRes;
   logic                 outSrc;
   logic [15:0]          outCnt;

   int nCmp = 0;
   int nMis = 0;

   wb_arbiter #(.NUM_REQ(NR), .SQN_W(6), .TAG_W(6), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .IN_valid(inValid), .IN_sqN(inSq), .IN_tagDst(inTag), .IN_nmDst(inNm), .IN_result(inRes),
      .OUT_stall(outStall),
      .IN_invalidate(inInv), .IN_invalidateSqN(inInvSq),
      .OUT_valid(outValid), .OUT_sqN(outSq), .OUT_tagDst(outTag), .OUT_nmDst(outNm),
      .OUT_result(outRes), .OUT_src(outSrc), .OUT_conflictCnt(outCnt)
   );

   always #5 clk = ~clk;

   bit          mV   [NR][2];
   logic [5:0]  mSq  [NR][2];
   logic [5:0]  mTag [NR][2];
   logic [4:0]  mNm  [NR][2];
   logic [31:0] mRes [NR][2];
   bit          eValid;
   logic [5:0]  eSq, eTag;
   logic [4:0]  eNm;
   logic [31:0] eRes;
   int          eSrc, eCnt;

   // Signed distance a-b folded into -32..31.
   function automatic int sdiff(input logic [5:0] a, input logic [5:0] b);
      int d;
      d = (int'(a) - int'(b) + 64) % 64;
      if (d >= 32) d -= 64;
      return d;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < NR; u++)
         for (int s = 0; s < 2; s++) mV[u][s] = 0;
      eValid = 0; eSq = '0; eTag = '0; eNm = '0; eRes = '0; eSrc = 0; eCnt = 0;
   endtask

   task automatic model_edge();
      bit pre [NR][2];
      int nv, bu, bs, ws;
      bit found;
      nv = 0;
      for (int u = 0; u < NR; u++)
         for (int s = 0; s < 2; s++) begin
            pre[u][s] = mV[u][s];
            if (mV[u][s]) nv++;
         end
      if (nv > 1 && eCnt < 65535) eCnt++;
      found = 0; bu = 0; bs = 0;
      for (int u = 0; u < NR; u++)
         for (int s = 0; s < 2; s++)
            if (mV[u][s] && !(inInv && sdiff(mSq[u][s], inInvSq) > 0))
               if (!found || sdiff(mSq[u][s], mSq[bu][bs]) < 0) begin
                  found = 1; bu = u; bs = s;
               end
      eValid = found;
      if (found) begin
         eSq = mSq[bu][bs]; eTag = mTag[bu][bs]; eNm = mNm[bu][bs]; eRes = mRes[bu][bs];
         eSrc = bu; mV[bu][bs] = 0;
      end
      if (inInv)
         for (int u = 0; u < NR; u++)
            for (int s = 0; s < 2; s++)
               if (mV[u][s] && sdiff(mSq[u][s], inInvSq) > 0) mV[u][s] = 0;
      for (int u = 0; u < NR; u++)
         if (inValid[u] && !(pre[u][0] && pre[u][1]) && !(inInv && sdiff(inSq[u], inInvSq) > 0)) begin
            ws = pre[u][0] ? 1 : 0;
            mV[u][ws] = 1; mSq[u][ws] = inSq[u]; mTag[u][ws] = inTag[u];
            mNm[u][ws] = inNm[u]; mRes[u][ws] = inRes[u];
         end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      inValid = '0;
      inInv   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; inValid = '0; inInv = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic offer(input int u, input logic [5:0] sq, input logic [5:0] tag,
                        input logic [4:0] nm, input logic [31:0] res);
      inValid[u] = 1'b1; inSq[u] = sq; inTag[u] = tag; inNm[u] = nm; inRes[u] = res;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      offer(0, 6'd1, 6'd2, 5'd3, 32'hAAAA);
      offer(1, 6'd4, 6'd5, 5'd6, 32'hBBBB);
      repeat (2) @(posedge clk);
      #1;
      nCmp++; if (outValid !== 1'b0) begin nMis++; $display("FAIL reset_valid got=%0b exp=0", outValid); end
      nCmp++; if (outStall !== 2'b00) begin nMis++; $display("FAIL reset_stall got=%0b exp=0", outStall); end
      nCmp++; if (outCnt !== 16'd0) begin nMis++; $display("FAIL reset_cnt got=%0d exp=0", outCnt); end
      nCmp++; if ({outSq, outTag, outNm, outRes, outSrc} !== '0) begin
         nMis++; $display("FAIL reset_fields got=%0h/%0h/%0h/%0h/%0h exp=0", outSq, outTag, outNm, outRes, outSrc);
      end
      rst = 1'b0; inValid = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         nCmp++; if (outValid !== 1'b0) begin nMis++; $display("FAIL reset_offer_dropped i=%0d got=%0b exp=0", i, outValid); end
      end
   endtask

   task automatic test_single_offer();
      do_reset();
      offer(0, 6'd5, 6'd9, 5'd3, 32'h1234);
      tick();
      nCmp++; if (outValid !== 1'b0) begin nMis++; $display("FAIL single_c2_valid got=%0b exp=0", outValid); end
      tick();
      nCmp++; if (outValid !== 1'b1) begin nMis++; $display("FAIL single_c3_valid got=%0b exp=1", outValid); end
      nCmp++; if (outSrc !== 1'b0) begin nMis++; $display("FAIL single_src got=%0d exp=0", outSrc); end
      nCmp++; if (outSq !== 6'd5) begin nMis++; $display("FAIL single_sqN got=%0d exp=5", outSq); end
      nCmp++; if (outTag !== 6'd9) begin nMis++; $display("FAIL single_tag got=%0d exp=9", outTag); end
      nCmp++; if (outNm !== 5'd3) begin nMis++; $display("FAIL single_nm got=%0d exp=3", outNm); end
      nCmp++; if (outRes !== 32'h1234) begin nMis++; $display("FAIL single_result got=%0h exp=1234", outRes); end
      nCmp++; if (outCnt !== 16'd0) begin nMis++; $display("FAIL single_cnt got=%0d exp=0", outCnt); end
      tick();
      nCmp++; if (outValid !== 1'b0) begin nMis++; $display("FAIL single_c4_valid got=%0b exp=0", outValid); end
      nCmp++; if (outSq !== 6'd5) begin nMis++; $display("FAIL single_hold_sqN got=%0d exp=5", outSq); end
   endtask

   task automatic test_contention();
      do_reset();
      offer(0, 6'd7, 6'd1, 5'd1, 32'h70);
      offer(1, 6'd6, 6'd2, 5'd2, 32'h60);
      tick();
      tick();
      nCmp++; if (outValid !== 1'b1 || outSrc !== 1'b1 || outSq !== 6'd6) begin
         nMis++; $display("FAIL contention_first got=v%0b s%0d q%0d exp=v1 s1 q6", outValid, outSrc, outSq);
      end
      tick();
      nCmp++; if (outValid !== 1'b1 || outSrc !== 1'b0 || outSq !== 6'd7) begin
         nMis++; $display("FAIL contention_second got=v%0b s%0d q%0d exp=v1 s0 q7", outValid, outSrc, outSq);
      end
      nCmp++; if (outRes !== 32'h70) begin nMis++; $display("FAIL contention_result got=%0h exp=70", outRes); end
      nCmp++; if (outCnt !== 16'd1) begin nMis++; $display("FAIL contention_cnt got=%0d exp=1", outCnt); end
      tick();
      nCmp++; if (outValid !== 1'b0 || outCnt !== 16'd1) begin
         nMis++; $display("FAIL contention_after got=v%0b c%0d exp=v0 c1", outValid, outCnt);
      end
   endtask

   task automatic test_wraparound();
      do_reset();
      offer(0, 6'd62, 6'd3, 5'd4, 32'h62);
      offer(1, 6'd1, 6'd4, 5'd5, 32'h01);
      tick();
      tick();
      nCmp++; if (outValid !== 1'b1 || outSrc !== 1'b0 || outSq !== 6'd62) begin
         nMis++; $display("FAIL wrap_first got=v%0b s%0d q%0d exp=v1 s0 q62", outValid, outSrc, outSq);
      end
      tick();
      nCmp++; if (outValid !== 1'b1 || outSrc !== 1'b1 || outSq !== 6'd1) begin
         nMis++; $display("FAIL wrap_second got=v%0b s%0d q%0d exp=v1 s1 q1", outValid, outSrc, outSq);
      end
   endtask

   task automatic test_backpressure();
      logic [5:0] got [$];
      logic [5:0] exp [5] = '{6'd20, 6'd21, 6'd22, 6'd30, 6'd31};
      logic [5:0] g;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i < 3) begin
            offer(0, 6'(30 + i), 6'd7, 5'd7, 32'(i));
            offer(1, 6'(20 + i), 6'd8, 5'd8, 32'(100 + i));
         end
         if (i == 2 || i == 3) begin
            nCmp++; if (outStall !== 2'b01) begin nMis++; $display("FAIL bp_stall i=%0d got=%0b exp=01", i, outStall); end
         end
         tick();
         if (outValid) got.push_back(outSq);
      end
      nCmp++; if (got.size() != 5) begin nMis++; $display("FAIL bp_count got=%0d exp=5", got.size()); end
      for (int k = 0; k < 5; k++) begin
         g = (k < got.size()) ? got[k] : 6'h3F;
         nCmp++; if (g !== exp[k]) begin nMis++; $display("FAIL bp_order k=%0d got=%0d exp=%0d", k, g, exp[k]); end
      end
   endtask

   task automatic test_flush();
      logic [5:0] got [$];
      logic [5:0] exp [4] = '{6'd1, 6'd2, 6'd3, 6'd4};
      logic [5:0] g;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: begin offer(0, 6'd8, 6'd1, 5'd1, 32'h8); offer(1, 6'd1, 6'd1, 5'd1, 32'h1); end
            1: begin offer(0, 6'd3, 6'd1, 5'd1, 32'h3); offer(1, 6'd2, 6'd1, 5'd1, 32'h2); end
            2: offer(1, 6'd4, 6'd1, 5'd1, 32'h4);
            3: begin inInv = 1'b1; inInvSq = 6'd4; offer(1, 6'd9, 6'd1, 5'd1, 32'h9); end
            default: ;
         endcase
         tick();
         if (outValid) got.push_back(outSq);
      end
      nCmp++; if (got.size() != 4) begin nMis++; $display("FAIL flush_count got=%0d exp=4", got.size()); end
      for (int k = 0; k < 4; k++) begin
         g = (k < got.size()) ? got[k] : 6'h3F;
         nCmp++; if (g !== exp[k]) begin nMis++; $display("FAIL flush_order k=%0d got=%0d exp=%0d", k, g, exp[k]); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      offer(0, 6'd10, 6'd1, 5'd1, 32'h10); offer(1, 6'd11, 6'd1, 5'd1, 32'h11);
      tick();
      offer(0, 6'd12, 6'd1, 5'd1, 32'h12); offer(1, 6'd13, 6'd1, 5'd1, 32'h13);
      tick();
      nCmp++; if (outStall !== 2'b10) begin nMis++; $display("FAIL rmid_stall_a got=%0b exp=10", outStall); end
      offer(0, 6'd14, 6'd1, 5'd1, 32'h14);
      tick();
      nCmp++; if (outStall !== 2'b01 || outValid !== 1'b1 || outSq !== 6'd11) begin
         nMis++; $display("FAIL rmid_before got=st%0b v%0b q%0d exp=st01 v1 q11", outStall, outValid, outSq);
      end
      #2 rst = 1'b1;
      #1;
      nCmp++; if (outValid !== 1'b0) begin nMis++; $display("FAIL rmid_valid got=%0b exp=0", outValid); end
      nCmp++; if (outStall !== 2'b00) begin nMis++; $display("FAIL rmid_stall got=%0b exp=00", outStall); end
      nCmp++; if (outSq !== 6'd0) begin nMis++; $display("FAIL rmid_sqN got=%0d exp=0", outSq); end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         nCmp++; if (outValid !== 1'b0 || outStall !== 2'b00) begin
            nMis++; $display("FAIL rmid_after i=%0d got=v%0b st%0b exp=v0 st00", i, outValid, outStall);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] sqCnt;
      bit flushed;
      do_reset();
      sqCnt = 6'($urandom);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
            continue;
         end
         flushed = 0;
         for (int u = 0; u < NR; u++)
            if ($urandom_range(0, 9) < 6) begin
               offer(u, sqCnt, 6'($urandom), 5'($urandom), $urandom);
               sqCnt = sqCnt + 6'($urandom_range(0, 2));
            end
         if ($urandom_range(0, 99) < 8) begin
            inInv = 1'b1;
            inInvSq = sqCnt - 6'($urandom_range(0, 6));
            flushed = 1;
         end
         for (int u = 0; u < NR; u++) begin
            nCmp++; if (outStall[u] !== (mV[u][0] && mV[u][1])) begin
               nMis++; $display("FAIL rnd_stall cyc=%0d u=%0d got=%0b exp=%0b", cyc, u, outStall[u], mV[u][0] && mV[u][1]);
            end
         end
         tick();
         if (flushed) sqCnt = inInvSq + 6'd1;
         nCmp++; if (outValid !== eValid) begin nMis++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, outValid, eValid); end
         nCmp++; if (outSrc !== 1'(eSrc)) begin nMis++; $display("FAIL rnd_src cyc=%0d got=%0d exp=%0d", cyc, outSrc, eSrc); end
         nCmp++; if (outSq !== eSq) begin nMis++; $display("FAIL rnd_sqN cyc=%0d got=%0d exp=%0d", cyc, outSq, eSq); end
         nCmp++; if (outTag !== eTag) begin nMis++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", cyc, outTag, eTag); end
         nCmp++; if (outNm !== eNm) begin nMis++; $display("FAIL rnd_nm cyc=%0d got=%0d exp=%0d", cyc, outNm, eNm); end
         nCmp++; if (outRes !== eRes) begin nMis++; $display("FAIL rnd_result cyc=%0d got=%0h exp=%0h", cyc, outRes, eRes); end
         nCmp++; if (outCnt !== 16'(eCnt)) begin nMis++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, outCnt, eCnt); end
      end
   endtask

   initial begin
      inValid = '0; inSq = '0; inTag = '0; inNm = '0; inRes = '0;
      inInv = 1'b0; inInvSq = '0; rst = 1'b0;
      test_reset();
      test_single_offer();
      test_contention();
      test_wraparound();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
      $finish;
   end
endmodule
